// File: rtl/pipeline_sequencer.sv
// Stall/flush/PC-sequencing controller for the five-stage pipeline: reset-vector
// load, load-use bubbles, branch squash, and interrupt drain/push/vector entry.
//
// state   | meaning
// VEC_HI  | load PC[31:16] from vector word vec_base
// VEC_LO  | load PC[15:0] from vector word vec_base+1, ack if interrupt vector
// RUN     | normal issue: interrupt entry, branch, load-use bubble, increment
// DRAIN   | hold fetch, let older instructions retire
// PUSH_HI | push resume PC[31:16]
// PUSH_LO | push resume PC[15:0]
module pipeline_sequencer #(
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [15:0] RST_VEC      = 16'h0000,
    parameter logic [15:0] INT_VEC      = 16'h0002
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        de_mem_read,
    input  logic [2:0]  de_rdst,
    input  logic [2:0]  fd_rsrc1,
    input  logic [2:0]  fd_rsrc2,
    input  logic        fd_use1,
    input  logic        fd_use2,
    input  logic        ex_branch_taken,
    input  logic        int_req,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        pc_half,
    output logic        fd_write,
    output logic        fd_flush,
    output logic        de_flush,
    output logic        vec_rd,
    output logic [15:0] vec_addr,
    output logic        stk_push,
    output logic        stk_word_sel,
    output logic        int_ack,
    output logic        busy
);

    localparam logic [2:0] VEC_HI  = 3'd0;
    localparam logic [2:0] VEC_LO  = 3'd1;
    localparam logic [2:0] RUN     = 3'd2;
    localparam logic [2:0] DRAIN   = 3'd3;
    localparam logic [2:0] PUSH_HI = 3'd4;
    localparam logic [2:0] PUSH_LO = 3'd5;

    localparam logic [1:0] SEL_INC = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    logic [2:0]  state, state_nxt;
    logic [15:0] vec_base, vec_base_nxt;
    logic [2:0]  drain_cnt, drain_cnt_nxt;
    logic        int_pend;
    logic        hazard;

    assign hazard = de_mem_read &&
                    ((fd_use1 && (fd_rsrc1 == de_rdst)) ||
                     (fd_use2 && (fd_rsrc2 == de_rdst)));

    always_comb begin
        state_nxt     = state;
        vec_base_nxt  = vec_base;
        drain_cnt_nxt = drain_cnt;
        pc_write      = 1'b0;
        pc_sel        = SEL_INC;
        pc_half       = 1'b0;
        fd_write      = 1'b0;
        fd_flush      = 1'b0;
        de_flush      = 1'b0;
        vec_rd        = 1'b0;
        vec_addr      = 16'h0000;
        stk_push      = 1'b0;
        stk_word_sel  = 1'b0;
        int_ack       = 1'b0;
        busy          = 1'b0;

        // Outputs follow reset immediately, independent of the clock.
        if (!reset) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
            busy     = 1'b1;
        end else begin
            case (state)
                VEC_HI, VEC_LO: begin
                    vec_rd   = 1'b1;
                    pc_write = 1'b1;
                    pc_sel   = SEL_MEM;
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                    busy     = 1'b1;
                    if (state == VEC_HI) begin
                        vec_addr  = vec_base;
                        pc_half   = 1'b1;
                        state_nxt = VEC_LO;
                    end else begin
                        vec_addr  = vec_base + 16'd1;
                        int_ack   = (vec_base == INT_VEC);
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    // A branch in EX must redirect before the interrupt freezes the PC.
                    if (int_pend && !ex_branch_taken) begin
                        fd_flush      = 1'b1;
                        drain_cnt_nxt = DRAIN_LOAD;
                        state_nxt     = DRAIN;
                    end else if (ex_branch_taken) begin
                        pc_write = 1'b1;
                        pc_sel   = SEL_BR;
                        fd_write = 1'b1;
                        fd_flush = 1'b1;
                        de_flush = 1'b1;
                    end else if (hazard) begin
                        de_flush = 1'b1;
                    end else begin
                        pc_write = 1'b1;
                        fd_write = 1'b1;
                    end
                end
                DRAIN: begin
                    fd_flush = 1'b1;
                    busy     = 1'b1;
                    if (ex_branch_taken) begin
                        pc_write = 1'b1;
                        pc_sel   = SEL_BR;
                        de_flush = 1'b1;
                    end
                    if (drain_cnt == 3'd0) begin
                        state_nxt = PUSH_HI;
                    end else begin
                        drain_cnt_nxt = drain_cnt - 3'd1;
                    end
                end
                PUSH_HI, PUSH_LO: begin
                    stk_push = 1'b1;
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                    busy     = 1'b1;
                    if (state == PUSH_HI) begin
                        stk_word_sel = 1'b1;
                        state_nxt    = PUSH_LO;
                    end else begin
                        vec_base_nxt = INT_VEC;
                        state_nxt    = VEC_HI;
                    end
                end
                default: begin
                    busy      = 1'b1;
                    state_nxt = VEC_HI;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= VEC_HI;
            vec_base  <= RST_VEC;
            drain_cnt <= 3'd0;
        end else begin
            state     <= state_nxt;
            vec_base  <= vec_base_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Ack wins over a new request in the same cycle; a held request re-latches next edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_pend <= 1'b0;
        end else if (int_ack) begin
            int_pend <= 1'b0;
        end else if (int_req) begin
            int_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed scenarios plus random traffic, every
// cycle compared against a script-queue reference model and a small PC/stack datapath.
module tb_pipeline_sequencer;

    localparam int          D  = 3;
    localparam logic [15:0] RV = 16'h0000;
    localparam logic [15:0] IV = 16'h0002;

    logic        clk = 1'b0;
    logic        reset;
    logic        de_mem_read;
    logic [2:0]  de_rdst, fd_rsrc1, fd_rsrc2;
    logic        fd_use1, fd_use2, ex_branch_taken, int_req;
    logic        pc_write, pc_half, fd_write, fd_flush, de_flush, vec_rd;
    logic [1:0]  pc_sel;
    logic [15:0] vec_addr;
    logic        stk_push, stk_word_sel, int_ack, busy;

    pipeline_sequencer #(.DRAIN_CYCLES(D), .RST_VEC(RV), .INT_VEC(IV)) dut (
        .clk(clk), .reset(reset), .de_mem_read(de_mem_read), .de_rdst(de_rdst),
        .fd_rsrc1(fd_rsrc1), .fd_rsrc2(fd_rsrc2), .fd_use1(fd_use1), .fd_use2(fd_use2),
        .ex_branch_taken(ex_branch_taken), .int_req(int_req),
        .pc_write(pc_write), .pc_sel(pc_sel), .pc_half(pc_half), .fd_write(fd_write),
        .fd_flush(fd_flush), .de_flush(de_flush), .vec_rd(vec_rd), .vec_addr(vec_addr),
        .stk_push(stk_push), .stk_word_sel(stk_word_sel), .int_ack(int_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    // Tiny datapath: PC register, vector memory, stack capture.
    logic [15:0] mem [0:3];
    logic [31:0] dp_pc = 32'h0;
    logic [31:0] br_target;
    logic [15:0] stk[$];
    int          ack_count = 0;

    always @(posedge clk) begin
        if (reset) begin
            if (stk_push) stk.push_back(stk_word_sel ? dp_pc[31:16] : dp_pc[15:0]);
            if (int_ack) ack_count <= ack_count + 1;
            if (pc_write) begin
                case (pc_sel)
                    2'b00: dp_pc <= dp_pc + 32'd1;
                    2'b01: dp_pc <= br_target;
                    2'b10: if (pc_half) dp_pc[31:16] <= mem[vec_addr[1:0]];
                           else         dp_pc[15:0]  <= mem[vec_addr[1:0]];
                    default: ;
                endcase
            end
        end
    end

    // Reference model: a queue of scripted sequence slots; empty queue means normal issue.
    typedef enum logic [2:0] {S_VHI, S_VLO, S_DRN, S_PHI, S_PLO} step_t;
    step_t       script[$];
    logic [15:0] m_base;
    logic        m_pend;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    function automatic logic [27:0] pack(input logic pw, input logic [1:0] ps, input logic ph,
                                         input logic fw, input logic ff, input logic df,
                                         input logic vr, input logic [15:0] va, input logic sp,
                                         input logic sw, input logic ia, input logic bz);
        return {pw, ps, ph, fw, ff, df, vr, va, sp, sw, ia, bz};
    endfunction

    function automatic void model_reset();
        script.delete();
        script.push_back(S_VHI);
        script.push_back(S_VLO);
        m_base = RV;
        m_pend = 1'b0;
    endfunction

    function automatic logic [27:0] model_out();
        logic pw, ph, fw, ff, df, vr, sp, sw, ia, bz, hz;
        logic [1:0]  ps;
        logic [15:0] va;
        {pw, ph, fw, ff, df, vr, sp, sw, ia, bz} = '0;
        ps = 2'b00;
        va = 16'h0;
        hz = de_mem_read && ((fd_use1 && fd_rsrc1 == de_rdst) || (fd_use2 && fd_rsrc2 == de_rdst));
        if (!reset) begin
            ff = 1; df = 1; bz = 1;
        end else if (script.size() == 0) begin
            if (m_pend && !ex_branch_taken) ff = 1;
            else if (ex_branch_taken) begin pw = 1; ps = 2'b01; fw = 1; ff = 1; df = 1; end
            else if (hz) df = 1;
            else begin pw = 1; fw = 1; end
        end else begin
            case (script[0])
                S_VHI: begin vr = 1; va = m_base; pw = 1; ps = 2'b10; ph = 1; ff = 1; df = 1; bz = 1; end
                S_VLO: begin vr = 1; va = m_base + 16'd1; pw = 1; ps = 2'b10; ff = 1; df = 1; bz = 1;
                             ia = (m_base == IV); end
                S_DRN: begin ff = 1; bz = 1;
                             if (ex_branch_taken) begin pw = 1; ps = 2'b01; df = 1; end end
                S_PHI: begin sp = 1; sw = 1; ff = 1; df = 1; bz = 1; end
                default: begin sp = 1; ff = 1; df = 1; bz = 1; end
            endcase
        end
        return pack(pw, ps, ph, fw, ff, df, vr, va, sp, sw, ia, bz);
    endfunction

    function automatic void model_step();
        logic [27:0] e;
        e = model_out();
        if (!reset) begin
            model_reset();
            return;
        end
        if (script.size() != 0) begin
            void'(script.pop_front());
        end else if (m_pend && !ex_branch_taken) begin
            for (int k = 0; k < D; k++) script.push_back(S_DRN);
            script.push_back(S_PHI);
            script.push_back(S_PLO);
            script.push_back(S_VHI);
            script.push_back(S_VLO);
            m_base = IV;
        end
        if (e[1]) m_pend = 1'b0;
        else if (int_req) m_pend = 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [27:0] o, e;
        @(negedge clk);
        e = model_out();
        o = pack(pc_write, pc_sel, pc_half, fd_write, fd_flush, de_flush, vec_rd, vec_addr,
                 stk_push, stk_word_sel, int_ack, busy);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL cycle%0d_outputs observed=%h expected=%h", cyc, o, e);
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (int_ack !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    int n, sbase, abase;

    initial begin
        reset = 1'b0;
        {de_mem_read, fd_use1, fd_use2, ex_branch_taken, int_req} = '0;
        de_rdst = 0; fd_rsrc1 = 0; fd_rsrc2 = 0;
        br_target = 32'h0;
        mem[0] = 16'h0000; mem[1] = 16'h0040; mem[2] = 16'h0000; mem[3] = 16'h0100;
        model_reset();
        #1;
        tick();
        chk("reset_busy", {31'd0, busy}, 32'd1);

        // Reset vector fetch
        reset = 1'b1;
        tick();
        tick();
        chk("reset_pc", dp_pc, 32'h0000_0040);
        chk("busy_run", {31'd0, busy}, 32'd0);

        // Load-use hazard on rsrc2
        de_mem_read = 1; de_rdst = 3; fd_rsrc1 = 1; fd_rsrc2 = 3; fd_use1 = 1; fd_use2 = 1;
        #1;
        chk("lu_stall", {29'd0, pc_write, fd_write, de_flush}, 32'b001);
        tick();
        de_mem_read = 0;
        #1;
        chk("lu_one_bubble", {31'd0, pc_write}, 32'd1);
        tick();
        de_mem_read = 1; fd_use2 = 0;
        #1;
        chk("lu_no_use", {31'd0, pc_write}, 32'd1);
        tick();
        fd_use2 = 1; fd_rsrc2 = 2;
        #1;
        chk("lu_other_reg", {31'd0, fd_write}, 32'd1);
        tick();
        fd_rsrc2 = 3; ex_branch_taken = 1; br_target = 32'h0000_0011;
        #1;
        chk("br_over_lu", {27'd0, pc_sel, fd_flush, de_flush, fd_write}, 32'b01111);
        tick();
        chk("br_pc", dp_pc, 32'h0000_0011);
        {de_mem_read, ex_branch_taken} = '0;

        // Interrupt entry with PC 0x00010020
        reset = 1'b0;
        mem[0] = 16'h0001; mem[1] = 16'h0020;
        tick();
        reset = 1'b1;
        sbase = stk.size();
        tick();
        int_req = 1;
        tick();
        int_req = 0;
        wait_ack(n);
        chk("int_latency", n, D + 4);
        chk("push_count", stk.size() - sbase, 2);
        chk("push_hi", {16'd0, stk[sbase]}, 32'h0001);
        chk("push_lo", {16'd0, stk[sbase+1]}, 32'h0020);
        tick();
        chk("int_pc", dp_pc, 32'h0000_0100);

        // Branch during drain redirects the resume PC
        sbase = stk.size();
        int_req = 1;
        tick();
        int_req = 0;
        tick();
        ex_branch_taken = 1; br_target = 32'h0000_0080;
        #1;
        chk("drain_br", {29'd0, pc_write, pc_sel}, 32'b101);
        tick();
        ex_branch_taken = 0;
        wait_ack(n);
        chk("drain_br_latency", n, 5);
        chk("drain_push_hi", {16'd0, stk[sbase]}, 32'h0000);
        chk("drain_push_lo", {16'd0, stk[sbase+1]}, 32'h0080);
        tick();

        // Reset during PUSH_LO
        sbase = stk.size();
        int_req = 1;
        tick();
        int_req = 0;
        for (int k = 0; k < D + 2; k++) tick();
        chk("in_push_lo", {30'd0, stk_push, stk_word_sel}, 32'b10);
        reset = 1'b0;
        #1;
        chk("async_reset_out",
            {4'd0, pack(pc_write, pc_sel, pc_half, fd_write, fd_flush, de_flush, vec_rd, vec_addr,
                        stk_push, stk_word_sel, int_ack, busy)},
            {4'd0, pack(0, 2'b00, 0, 0, 1, 1, 0, 16'h0, 0, 0, 0, 1)});
        tick();
        chk("partial_push", stk.size() - sbase, 1);
        reset = 1'b1;
        abase = ack_count;
        tick();
        tick();
        chk("no_ack_after_reset", ack_count - abase, 0);
        chk("reload_pc", dp_pc, 32'h0001_0020);
        for (int k = 0; k < 4; k++) tick();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            de_mem_read     = 1'($urandom_range(0, 1));
            de_rdst         = 3'($urandom_range(0, 3));
            fd_rsrc1        = 3'($urandom_range(0, 3));
            fd_rsrc2        = 3'($urandom_range(0, 3));
            fd_use1         = 1'($urandom_range(0, 1));
            fd_use2         = 1'($urandom_range(0, 1));
            int_req         = ($urandom_range(0, 15) == 0);
            reset           = ($urandom_range(0, 299) != 0);
            br_target       = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
